decodificador_secuencia: RTL

Receiving end of the arbitrary-sequence counter link. It samples the 4-bit counter code each clock and decodes it back to its ordinal position (0..7) within the programmed 8-value sequence. It locks onto the sequence after a run of correct successor transitions, then flags every break in the sequence. It sits downstream of the contador block as its checker/decoder.

---
 rtl/decodificador_secuencia.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/decodificador_secuencia.sv
`default_nettype none
// ============================================================================
// Module   : decodificador_secuencia
// Brief    : Decodes a programmed 8-code counter sequence to its ordinal,
//            locks after a run of correct successors and flags sequence breaks.
// Revision : 1.0 - initial release
// ============================================================================
module decodificador_secuencia #(
    parameter logic [3:0] S0     = 4'd0,
    parameter logic [3:0] S1     = 4'd4,
    parameter logic [3:0] S2     = 4'd14,
    parameter logic [3:0] S3     = 4'd6,
    parameter logic [3:0] S4     = 4'd3,
    parameter logic [3:0] S5     = 4'd12,
    parameter logic [3:0] S6     = 4'd11,
    parameter logic [3:0] S7     = 4'd13,
    parameter int         LOCK_N = 2,
    parameter int         ERR_W  = 8
) (
    input  logic             C,
    input  logic             R,
    input  logic [3:0]       Q,
    input  logic             EN,
    output logic [2:0]       IDX,
    output logic             VALID,
    output logic             LOCK,
    output logic             ERR,
    output logic [ERR_W-1:0] ERR_CNT
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [31:0] c_seq    = {S7, S6, S5, S4, S3, S2, S1, S0};
    localparam logic [3:0]  c_lock_n = 4'(LOCK_N);

    state_t           state_q, state_d;
    logic [2:0]       prev_q, prev_d;
    logic [2:0]       run_q, run_d;
    logic             valid_q, valid_d;
    logic             lock_q, lock_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;

    logic             w_member;
    logic [2:0]       w_k;
    logic [2:0]       w_succ;
    logic [3:0]       w_succ_code;

    // Scan downwards so the lowest matching index wins on duplicate codes.
    always_comb begin
        w_member = 1'b0;
        w_k      = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (Q == c_seq[i*4 +: 4]) begin
                w_member = 1'b1;
                w_k      = 3'(i);
            end
        end
    end

    assign w_succ      = prev_q + 3'd1;
    assign w_succ_code = c_seq[{w_succ, 2'b00} +: 4];

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        run_d   = run_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        if (EN) begin
            valid_d = w_member;
            case (state_q)
                HUNT: begin
                    if (w_member) begin
                        prev_d  = w_k;
                        run_d   = 3'd0;
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    if (!w_member) begin
                        run_d   = 3'd0;
                        state_d = HUNT;
                    end else if (w_k == w_succ) begin
                        prev_d = w_k;
                        run_d  = run_q + 3'd1;
                        if (({1'b0, run_q} + 4'd1) == c_lock_n) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        prev_d = w_k;
                        run_d  = 3'd0;
                    end
                end
                LOCKED: begin
                    if (Q == w_succ_code) begin
                        prev_d = w_succ;
                    end else begin
                        err_d = 1'b1;
                        run_d = 3'd0;
                        if (cnt_q != {ERR_W{1'b1}}) begin
                            cnt_d = cnt_q + ERR_W'(1);
                        end
                        if (w_member) begin
                            prev_d  = w_k;
                            state_d = SYNC;
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    run_d   = 3'd0;
                end
            endcase
        end
        lock_d = (state_d == LOCKED);
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_q <= HUNT;
            prev_q  <= 3'd0;
            run_q   <= 3'd0;
            valid_q <= 1'b0;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            run_q   <= run_d;
            valid_q <= valid_d;
            lock_q  <= lock_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign IDX     = prev_q;
    assign VALID   = valid_q;
    assign LOCK    = lock_q;
    assign ERR     = err_q;
    assign ERR_CNT = cnt_q;

endmodule
`default_nettype wire
